// File: rtl/xc_sha3_defs.sv
// Shared definitions for the SHA3 lane-index decode path: lane count, FSM states, row width.
package xc_sha3_defs;

  localparam int LANES = 25;

  localparam logic [4:0] ROW_W = 5'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    PINV = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/xc_sha3_mod5.sv
// Combinational mod-5 reduction for inputs 0..16 using compare/subtract, no divider.
module xc_sha3_mod5 (
  input  logic [4:0] val,
  output logic [2:0] res
);

  logic [4:0] red;

  always_comb begin
    red = val;
    if (val >= 5'd15)      red = val - 5'd15;
    else if (val >= 5'd10) red = val - 5'd10;
    else if (val >= 5'd5)  red = val - 5'd5;
    res = red[2:0];
  end

endmodule

// File: rtl/xc_sha3_idx_decode.sv
// Recovers Keccak lane coordinates (x, y) from a scaled lane address, optionally undoing pi.
module xc_sha3_idx_decode
  import xc_sha3_defs::*;
#(
  parameter int LANES_P = LANES
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] addr,
  input  logic [1:0]  shamt,
  input  logic        f_pinv,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [4:0]  x,
  output logic [4:0]  y,
  output logic        err
);

  state_t     state, state_next;
  logic [4:0] rem, rem_next;
  logic [2:0] ycnt, ycnt_next;
  logic [4:0] x_q, x_next;
  logic [4:0] y_q, y_next;
  logic       err_q, err_next;
  logic       pinv_q, pinv_next;

  logic [31:0] idx;
  logic [31:0] low_mask;
  logic        misaligned;
  logic        out_of_range;
  logic [4:0]  pinv_sum;
  logic [2:0]  pinv_mod;

  assign idx          = addr >> shamt;
  assign low_mask     = (32'h1 << shamt) - 32'h1;
  assign misaligned   = (addr & low_mask) != 32'h0;
  assign out_of_range = idx >= 32'(LANES_P);

  // Inverse pi: x' = (x + 3y) mod 5, sum never exceeds 16.
  assign pinv_sum = x_q + (y_q << 1) + y_q;

  xc_sha3_mod5 u_mod5 (
    .val (pinv_sum),
    .res (pinv_mod)
  );

  assign req_ready = (state == IDLE) && !reset;
  assign rsp_valid = (state == DONE);
  assign x         = x_q;
  assign y         = y_q;
  assign err       = err_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      rem    <= 5'd0;
      ycnt   <= 3'd0;
      x_q    <= 5'd0;
      y_q    <= 5'd0;
      err_q  <= 1'b0;
      pinv_q <= 1'b0;
    end else begin
      state  <= state_next;
      rem    <= rem_next;
      ycnt   <= ycnt_next;
      x_q    <= x_next;
      y_q    <= y_next;
      err_q  <= err_next;
      pinv_q <= pinv_next;
    end
  end

  always_comb begin
    state_next = state;
    rem_next   = rem;
    ycnt_next  = ycnt;
    x_next     = x_q;
    y_next     = y_q;
    err_next   = err_q;
    pinv_next  = pinv_q;

    case (state)
      IDLE: begin
        if (req_valid) begin
          ycnt_next = 3'd0;
          pinv_next = f_pinv;
          if (misaligned || out_of_range) begin
            err_next   = 1'b1;
            x_next     = 5'd0;
            y_next     = 5'd0;
            state_next = DONE;
          end else begin
            err_next   = 1'b0;
            rem_next   = idx[4:0];
            state_next = DIV;
          end
        end
      end
      DIV: begin
        // Repeated subtraction: ycnt ends as idx/5, rem as idx%5.
        if (rem >= ROW_W) begin
          rem_next  = rem - ROW_W;
          ycnt_next = ycnt + 3'd1;
        end else begin
          x_next     = rem;
          y_next     = {2'b00, ycnt};
          state_next = pinv_q ? PINV : DONE;
        end
      end
      PINV: begin
        x_next     = {2'b00, pinv_mod};
        y_next     = x_q;
        state_next = DONE;
      end
      DONE: begin
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_xc_sha3_idx_decode.sv
// Directed vector bench for xc_sha3_idx_decode: table of decodes, backpressure, reset abort, round-trip sweep.
module tb_xc_sha3_idx_decode;

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] addr;
  logic [1:0]  shamt;
  logic        f_pinv;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [4:0]  x;
  logic [4:0]  y;
  logic        err;

  int checks;
  int errors;

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  shamt;
    logic        f_pinv;
    logic [4:0]  ex;
    logic [4:0]  ey;
    logic        eerr;
    int          elat;
  } vec_t;

  vec_t vecs[10];

  xc_sha3_idx_decode dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .addr      (addr),
    .shamt     (shamt),
    .f_pinv    (f_pinv),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .x         (x),
    .y         (y),
    .err       (err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Issues one request and waits (bounded) for the response; lat counts edges after acceptance.
  task automatic applyStimulus(input logic [31:0] a, input logic [1:0] s, input logic p,
                               output logic [4:0] gx, output logic [4:0] gy, output logic ge,
                               output int lat, output logic to);
    checkOutput("req_ready_idle", {31'd0, req_ready}, 32'd1);
    addr = a; shamt = s; f_pinv = p; req_valid = 1'b1;
    @(posedge clock); #1;
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(posedge clock); #1;
      lat++;
    end
    to = !rsp_valid;
    gx = x; gy = y; ge = err;
  endtask

  task automatic completeResponse();
    rsp_ready = 1'b1;
    @(posedge clock); #1;
    rsp_ready = 1'b0;
    checkOutput("rsp_valid_drop", {31'd0, rsp_valid}, 32'd0);
  endtask

  initial begin
    logic [4:0] gx, gy;
    logic       ge, to;
    int         lat;
    int         fwd;
    logic [4:0] hx, hy;
    logic       he;

    checks = 0; errors = 0;
    reset = 1'b1; req_valid = 1'b0; addr = 32'd0; shamt = 2'd0; f_pinv = 1'b0; rsp_ready = 1'b0;

    vecs[0] = '{32'h0000_0000, 2'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1};
    vecs[1] = '{32'h0000_0060, 2'd2, 1'b0, 5'd4, 5'd4, 1'b0, 5};
    vecs[2] = '{32'h0000_0032, 2'd1, 1'b0, 5'd0, 5'd0, 1'b1, 0};
    vecs[3] = '{32'h0000_000D, 2'd2, 1'b0, 5'd0, 5'd0, 1'b1, 0};
    vecs[4] = '{32'h0000_0007, 2'd0, 1'b1, 5'd0, 5'd2, 1'b0, 3};
    vecs[5] = '{32'h0000_0060, 2'd2, 1'b1, 5'd1, 5'd4, 1'b0, 6};
    vecs[6] = '{32'h0000_0068, 2'd3, 1'b0, 5'd3, 5'd2, 1'b0, 3};
    vecs[7] = '{32'h0000_0016, 2'd1, 1'b1, 5'd2, 5'd1, 1'b0, 4};
    vecs[8] = '{32'h8000_0000, 2'd0, 1'b0, 5'd0, 5'd0, 1'b1, 0};
    vecs[9] = '{32'h0000_000C, 2'd3, 1'b1, 5'd0, 5'd0, 1'b1, 0};

    #1;
    checkOutput("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    checkOutput("reset_req_ready", {31'd0, req_ready}, 32'd0);
    checkOutput("reset_xy_err", {22'd0, x, y, err}, 32'd0);
    @(posedge clock); @(posedge clock); #1;
    reset = 1'b0;
    #1;

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].addr, vecs[i].shamt, vecs[i].f_pinv, gx, gy, ge, lat, to);
      checkOutput($sformatf("vec%0d_timeout", i), {31'd0, to}, 32'd0);
      checkOutput($sformatf("vec%0d_x", i), {27'd0, gx}, {27'd0, vecs[i].ex});
      checkOutput($sformatf("vec%0d_y", i), {27'd0, gy}, {27'd0, vecs[i].ey});
      checkOutput($sformatf("vec%0d_err", i), {31'd0, ge}, {31'd0, vecs[i].eerr});
      checkOutput($sformatf("vec%0d_lat", i), lat, vecs[i].elat);
      completeResponse();
    end

    // Backpressure: hold the response while a second request is presented.
    applyStimulus(32'h60, 2'd2, 1'b0, gx, gy, ge, lat, to);
    checkOutput("bp_timeout", {31'd0, to}, 32'd0);
    hx = gx; hy = gy; he = ge;
    addr = 32'h0; shamt = 2'd0; f_pinv = 1'b0; req_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clock); #1;
      checkOutput("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      checkOutput("bp_req_ready", {31'd0, req_ready}, 32'd0);
      checkOutput("bp_hold_xy", {22'd0, x, y, err}, {22'd0, hx, hy, he});
    end
    checkOutput("bp_held_x", {27'd0, x}, 32'd4);
    rsp_ready = 1'b1;
    @(posedge clock); #1;
    rsp_ready = 1'b0;
    checkOutput("bp_after_hs_ready", {31'd0, req_ready}, 32'd1);
    checkOutput("bp_after_hs_valid", {31'd0, rsp_valid}, 32'd0);
    checkOutput("bp_after_hs_hold", {22'd0, x, y, err}, {22'd0, 5'd4, 5'd4, 1'b0});
    @(posedge clock); #1;
    req_valid = 1'b0;
    checkOutput("bp_next_accepted", {31'd0, req_ready}, 32'd0);
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(posedge clock); #1;
      lat++;
    end
    checkOutput("bp_next_lat", lat, 1);
    checkOutput("bp_next_xy", {22'd0, x, y, err}, 32'd0);
    completeResponse();

    // Reset abort during DIV, starting from a non-zero previous result.
    applyStimulus(32'h68, 2'd3, 1'b0, gx, gy, ge, lat, to);
    checkOutput("pre_rst_x", {27'd0, gx}, 32'd3);
    completeResponse();
    addr = 32'h60; shamt = 2'd2; f_pinv = 1'b0; req_valid = 1'b1;
    @(posedge clock); #1;
    req_valid = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    #1;
    checkOutput("rst_div_valid", {31'd0, rsp_valid}, 32'd0);
    checkOutput("rst_div_xy_err", {22'd0, x, y, err}, 32'd0);
    checkOutput("rst_div_ready", {31'd0, req_ready}, 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    #1;
    checkOutput("rst_release_ready", {31'd0, req_ready}, 32'd1);
    for (int c = 0; c < 6; c++) begin
      @(posedge clock); #1;
      checkOutput("rst_no_stale_rsp", {31'd0, rsp_valid}, 32'd0);
    end

    // Round trip: re-encode each decode with the forward lane-index function.
    for (int idx = 0; idx < 25; idx++) begin
      for (int s = 0; s < 4; s++) begin
        for (int p = 0; p < 2; p++) begin
          applyStimulus(32'(idx) << s, 2'(s), p[0], gx, gy, ge, lat, to);
          if (gx >= 5'd5 || gy >= 5'd5) fwd = -1;
          else if (p == 0) fwd = int'(gx) + 5 * int'(gy);
          else fwd = int'(gy) + 5 * ((2 * int'(gx) + 3 * int'(gy)) % 5);
          checkOutput($sformatf("rt_i%0d_s%0d_p%0d", idx, s, p), fwd, idx);
          checkOutput("rt_err", {31'd0, ge | to}, 32'd0);
          checkOutput("rt_lat", lat, idx / 5 + 1 + p);
          completeResponse();
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
